// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory request/response, execute redirect,
// and the decode-facing instruction handshake.
interface ifu_fetch_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_fault, fetch_count,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_fault, fetch_count,
    output inst_ready
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction-fetch controller: owns the PC, keeps one memory read
// in flight at most, buffers the returned word and hands it to decode.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic               clk,
  input logic               rst,
  ifu_fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_fault;
  logic [31:0] r_count;

  logic        w_aligned;
  logic        w_req_valid;
  logic        w_req_hs;

  // Request is decoded from registered state only; ready never feeds back here.
  assign w_aligned   = (r_pc[1:0] == 2'b00);
  assign w_req_valid = (r_state == S_REQ) && w_aligned;
  assign w_req_hs    = w_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_state == S_HOLD);
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;
  assign bus.inst_fault     = r_fault;
  assign bus.fetch_count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_fault   <= 1'b0;
      r_count   <= 32'd0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (bus.redirect_valid) r_pc <= bus.redirect_pc;
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= w_req_hs ? S_DROP : S_REQ;
          end else if (!w_aligned) begin
            // Misaligned PC faults locally without touching memory.
            r_inst    <= 32'd0;
            r_inst_pc <= r_pc;
            r_fault   <= 1'b1;
            r_state   <= S_HOLD;
          end else if (w_req_hs) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
          end else if (bus.imem_rsp_valid) begin
            r_inst    <= bus.imem_rsp_data;
            r_inst_pc <= r_pc;
            r_fault   <= bus.imem_rsp_err;
            r_state   <= S_HOLD;
          end
        end

        S_DROP: begin
          if (bus.redirect_valid) r_pc <= bus.redirect_pc;
          if (bus.imem_rsp_valid) r_state <= S_REQ;
        end

        S_HOLD: begin
          // A redirect squashes the buffered word even if decode takes it now.
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= S_REQ;
          end else if (bus.inst_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_count <= r_count + 32'd1;
            r_state <= S_REQ;
          end
        end

        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Multi-cycle instruction-fetch controller. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and buffers the returned word. It presents that word with its PC to decode through a valid/ready handshake, and accepts next-PC redirects from execute. It sits between the instruction memory and `idu`, replacing the fixed one-cycle fetch path.

## Interface
- `RESET_PC`, default 32'h80000000: PC fetched first after reset.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `imem_req_valid`  output  1  read request pending.
- `imem_req_ready`  input  1  memory accepts the request this cycle.
- `imem_req_addr`  output  32  fetch address; equals current PC.
- `imem_rsp_valid`  input  1  read data valid, one pulse per accepted request.
- `imem_rsp_data`  input  32  instruction word.
- `imem_rsp_err`  input  1  access fault, qualified by `imem_rsp_valid`.
- `redirect_valid`  input  1  one-cycle pulse carrying a new PC (dnpc).
- `redirect_pc`  input  32  redirect target.
- `inst_valid`  output  1  buffered instruction available to decode.
- `inst_ready`  input  1  decode consumes the instruction this cycle.
- `inst`  output  32  instruction word.
- `inst_pc`  output  32  PC of `inst`.
- `inst_fault`  output  1  `inst` is invalid; fetch faulted (error or misaligned).
- `fetch_count`  output  32  instructions delivered since reset, wrapping modulo 2^32.

## Operation
- States: BOOT, REQ, WAIT, DROP, HOLD. The state is held in a register and reset to BOOT.
- BOOT: unconditionally moves to REQ on the next edge.
- REQ:
  - `imem_req_valid=1` only when `pc[1:0]==0`.
  - A misaligned PC issues no request; the block goes to HOLD with `inst_fault=1`, `inst=0`, `inst_pc=pc`.
  - Handshake (`valid&&ready`) moves the block to WAIT.
- WAIT: on `imem_rsp_valid`, latch `inst<=imem_rsp_data`, `inst_fault<=imem_rsp_err`, `inst_pc<=pc`, then go to HOLD.
- HOLD:
  - `inst_valid=1`; outputs stay stable until `inst_ready`.
  - On `inst_ready`: `pc<=pc+4` (32-bit wrap), `fetch_count++`, go to REQ.
- DROP: waits for the response to an abandoned request. That response is discarded, then the block goes to REQ.
- Redirect (`redirect_valid`) always wins and loads `pc<=redirect_pc`:
  - REQ without handshake: the address changes next cycle and the block stays in REQ. The address may change only on redirect; memory samples it only on handshake.
  - REQ with handshake in the same cycle: go to DROP.
  - WAIT without `imem_rsp_valid`: go to DROP.
  - WAIT with `imem_rsp_valid` in the same cycle: the response is discarded and the block goes to REQ.
  - DROP: PC updates and the block stays in DROP.
  - HOLD: the buffered instruction is discarded even if `inst_ready=1`, `fetch_count` is not incremented, and the block goes to REQ.
- `imem_rsp_valid` outside WAIT and DROP is ignored.
- At most one request is outstanding.

## Timing
- Values while `rst=0` (immediate, asynchronous):
  - `imem_req_valid=0`, `imem_req_addr=RESET_PC`
  - `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_fault=0`
  - `fetch_count=0`
- First request is asserted in cycle 1 after reset release; cycle 0 is BOOT.
- Latency:
  - Request handshake at cycle T and response at T+k (k≥1) give `inst_valid` at T+k+1.
  - Output handshake at cycle H gives the next `imem_req_valid` at H+1.
  - Zero-wait memory and always-ready decode give 3 cycles per instruction.
- `imem_req_valid`, `imem_req_addr` and `inst_*` decode from registered state only, with no combinational path from inputs.
- A redirect at cycle R puts `redirect_pc` on `imem_req_addr` at R+1, except from DROP, which first waits for the abandoned response.
- Reset asserted mid-WAIT or mid-DROP abandons the request. The memory is responsible for squashing it; a late response arrives in BOOT or REQ and is ignored.

## Test plan
- Boot:
  - Stimulus: release `rst`; `imem_req_ready=1`; memory returns 32'h00000013 one cycle after handshake; `inst_ready=1`.
  - Required: request at cycle 1, addr 0x80000000; `inst_valid` at cycle 3, `inst_pc` 0x80000000; next request at cycle 4, addr 0x80000004; `fetch_count` 1.
- Backpressure:
  - Stimulus: hold `inst_ready=0` for 5 cycles in HOLD.
  - Required: `inst`, `inst_pc`, `inst_valid` stable; no `imem_req_valid`; `fetch_count` unchanged.
- Redirect during WAIT:
  - Stimulus: pulse redirect to 0x80000100; response 32'hDEADBEEF arrives 3 cycles later.
  - Required: 32'hDEADBEEF never appears on `inst`; next request addr 0x80000100.
- Misaligned redirect:
  - Stimulus: redirect to 0x80000102.
  - Required: no memory request; `inst_valid=1`, `inst_fault=1`, `inst=0`, `inst_pc` 0x80000102.
- Error and redirect in HOLD:
  - Stimulus: response with `imem_rsp_err=1`; then pulse redirect to 0x80000200 together with `inst_ready` in HOLD.
  - Required: `inst_fault=1` on the response; on the redirect, `fetch_count` unchanged and next request addr 0x80000200.
- Reset mid-WAIT:
  - Stimulus: assert `rst` low, release, and inject a stray `imem_rsp_valid` in BOOT.
  - Required: all outputs at reset values during reset; stray response ignored; fetch restarts at 0x80000000.
